// File: rtl/axi_lite_arb2.sv
// axi_lite_arb2: round-robin arbiter sharing one AXI-Lite slave between two masters,
// one transaction in flight at a time, all channel forwarding combinational.
module axi_lite_arb2 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    m0_ar_valid,
    output logic                    m0_ar_ready,
    input  logic [ADDR_WIDTH-1:0]   m0_ar_addr,
    output logic                    m0_r_valid,
    input  logic                    m0_r_ready,
    output logic [DATA_WIDTH-1:0]   m0_r_data,
    output logic [1:0]              m0_r_resp,
    input  logic                    m0_aw_valid,
    output logic                    m0_aw_ready,
    input  logic [ADDR_WIDTH-1:0]   m0_aw_addr,
    input  logic                    m0_w_valid,
    output logic                    m0_w_ready,
    input  logic [DATA_WIDTH-1:0]   m0_w_data,
    input  logic [DATA_WIDTH/8-1:0] m0_w_strb,
    output logic                    m0_b_valid,
    input  logic                    m0_b_ready,
    output logic [1:0]              m0_b_resp,
    input  logic                    m1_ar_valid,
    output logic                    m1_ar_ready,
    input  logic [ADDR_WIDTH-1:0]   m1_ar_addr,
    output logic                    m1_r_valid,
    input  logic                    m1_r_ready,
    output logic [DATA_WIDTH-1:0]   m1_r_data,
    output logic [1:0]              m1_r_resp,
    input  logic                    m1_aw_valid,
    output logic                    m1_aw_ready,
    input  logic [ADDR_WIDTH-1:0]   m1_aw_addr,
    input  logic                    m1_w_valid,
    output logic                    m1_w_ready,
    input  logic [DATA_WIDTH-1:0]   m1_w_data,
    input  logic [DATA_WIDTH/8-1:0] m1_w_strb,
    output logic                    m1_b_valid,
    input  logic                    m1_b_ready,
    output logic [1:0]              m1_b_resp,
    output logic                    s_ar_valid,
    input  logic                    s_ar_ready,
    output logic [ADDR_WIDTH-1:0]   s_ar_addr,
    input  logic                    s_r_valid,
    output logic                    s_r_ready,
    input  logic [DATA_WIDTH-1:0]   s_r_data,
    input  logic [1:0]              s_r_resp,
    output logic                    s_aw_valid,
    input  logic                    s_aw_ready,
    output logic [ADDR_WIDTH-1:0]   s_aw_addr,
    output logic                    s_w_valid,
    input  logic                    s_w_ready,
    output logic [DATA_WIDTH-1:0]   s_w_data,
    output logic [DATA_WIDTH/8-1:0] s_w_strb,
    input  logic                    s_b_valid,
    output logic                    s_b_ready,
    input  logic [1:0]              s_b_resp,
    output logic [1:0]              gnt_o,
    output logic                    busy_o
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP} state_t;
    state_t state, state_nx;
    logic rr, rr_nx, sel, sel_nx, aw_done, aw_done_nx, w_done, w_done_nx;
    logic [1:0] rw_pref, rw_pref_nx, rd_req, wr_req;
    logic pick, both, in_ra, in_rd, in_wa, in_wb;

    assign rd_req = {m1_ar_valid, m0_ar_valid};
    assign wr_req = {m1_aw_valid & m1_w_valid, m0_aw_valid & m0_w_valid};
    // rr=1 favours m1; otherwise m0 wins whenever it is requesting
    assign pick = rr ? (rd_req[1] | wr_req[1]) : !(rd_req[0] | wr_req[0]);
    assign both = rd_req[pick] & wr_req[pick];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            rr      <= 1'b0;
            sel     <= 1'b0;
            rw_pref <= 2'b00;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_nx;
            rr      <= rr_nx;
            sel     <= sel_nx;
            rw_pref <= rw_pref_nx;
            aw_done <= aw_done_nx;
            w_done  <= w_done_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        rr_nx      = rr;
        sel_nx     = sel;
        rw_pref_nx = rw_pref;
        aw_done_nx = aw_done;
        w_done_nx  = w_done;
        case (state)
            IDLE: if (|(rd_req | wr_req)) begin
                sel_nx   = pick;
                state_nx = (rd_req[pick] && !(both && rw_pref[pick])) ? RD_ADDR : WR_ADDR;
                if (both) rw_pref_nx[pick] = !rw_pref[pick];
            end
            RD_ADDR: if (s_ar_valid && s_ar_ready) state_nx = RD_DATA;
            RD_DATA: if (s_r_valid && s_r_ready) begin
                state_nx = IDLE;
                rr_nx    = !sel;
            end
            WR_ADDR: begin
                aw_done_nx = aw_done | (s_aw_valid & s_aw_ready);
                w_done_nx  = w_done | (s_w_valid & s_w_ready);
                if (aw_done_nx && w_done_nx) begin
                    state_nx   = WR_RESP;
                    aw_done_nx = 1'b0;
                    w_done_nx  = 1'b0;
                end
            end
            WR_RESP: if (s_b_valid && s_b_ready) begin
                state_nx = IDLE;
                rr_nx    = !sel;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy_o = state != IDLE;
    assign gnt_o  = busy_o ? (sel ? 2'b10 : 2'b01) : 2'b00;
    assign in_ra  = state == RD_ADDR;
    assign in_rd  = state == RD_DATA;
    assign in_wa  = state == WR_ADDR;
    assign in_wb  = state == WR_RESP;

    assign s_ar_valid = in_ra && (sel ? m1_ar_valid : m0_ar_valid);
    assign s_ar_addr  = sel ? m1_ar_addr : m0_ar_addr;
    assign s_r_ready  = in_rd && (sel ? m1_r_ready : m0_r_ready);
    assign s_aw_valid = in_wa && !aw_done && (sel ? m1_aw_valid : m0_aw_valid);
    assign s_aw_addr  = sel ? m1_aw_addr : m0_aw_addr;
    assign s_w_valid  = in_wa && !w_done && (sel ? m1_w_valid : m0_w_valid);
    assign s_w_data   = sel ? m1_w_data : m0_w_data;
    assign s_w_strb   = sel ? m1_w_strb : m0_w_strb;
    assign s_b_ready  = in_wb && (sel ? m1_b_ready : m0_b_ready);

    assign m0_ar_ready = gnt_o[0] && in_ra && s_ar_ready;
    assign m0_r_valid  = gnt_o[0] && in_rd && s_r_valid;
    assign m0_r_data   = s_r_data;
    assign m0_r_resp   = s_r_resp;
    assign m0_aw_ready = gnt_o[0] && in_wa && !aw_done && s_aw_ready;
    assign m0_w_ready  = gnt_o[0] && in_wa && !w_done && s_w_ready;
    assign m0_b_valid  = gnt_o[0] && in_wb && s_b_valid;
    assign m0_b_resp   = s_b_resp;

    assign m1_ar_ready = gnt_o[1] && in_ra && s_ar_ready;
    assign m1_r_valid  = gnt_o[1] && in_rd && s_r_valid;
    assign m1_r_data   = s_r_data;
    assign m1_r_resp   = s_r_resp;
    assign m1_aw_ready = gnt_o[1] && in_wa && !aw_done && s_aw_ready;
    assign m1_w_ready  = gnt_o[1] && in_wa && !w_done && s_w_ready;
    assign m1_b_valid  = gnt_o[1] && in_wb && s_b_valid;
    assign m1_b_resp   = s_b_resp;
endmodule

// File: tb/tb_axi_lite_arb2.sv
// tb_axi_lite_arb2: two random AXI-Lite masters and a random-ready register slave around
// the arbiter; a transaction-level model predicts grants, op order and read data.
module tb_axi_lite_arb2;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        m_ar_valid[2], m_ar_ready[2], m_r_valid[2], m_r_ready[2];
    logic [3:0]  m_ar_addr[2], m_aw_addr[2], m_w_strb[2];
    logic [31:0] m_r_data[2], m_w_data[2];
    logic [1:0]  m_r_resp[2], m_b_resp[2];
    logic        m_aw_valid[2], m_aw_ready[2], m_w_valid[2], m_w_ready[2], m_b_valid[2], m_b_ready[2];
    logic        s_ar_valid, s_ar_ready, s_r_valid, s_r_ready, s_aw_valid, s_aw_ready;
    logic        s_w_valid, s_w_ready, s_b_valid, s_b_ready;
    logic [3:0]  s_ar_addr, s_aw_addr, s_w_strb;
    logic [31:0] s_r_data, s_w_data;
    logic [1:0]  s_r_resp, s_b_resp, gnt;
    logic        busy;

    axi_lite_arb2 #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_ar_valid(m_ar_valid[0]), .m0_ar_ready(m_ar_ready[0]), .m0_ar_addr(m_ar_addr[0]),
        .m0_r_valid(m_r_valid[0]), .m0_r_ready(m_r_ready[0]), .m0_r_data(m_r_data[0]), .m0_r_resp(m_r_resp[0]),
        .m0_aw_valid(m_aw_valid[0]), .m0_aw_ready(m_aw_ready[0]), .m0_aw_addr(m_aw_addr[0]),
        .m0_w_valid(m_w_valid[0]), .m0_w_ready(m_w_ready[0]), .m0_w_data(m_w_data[0]), .m0_w_strb(m_w_strb[0]),
        .m0_b_valid(m_b_valid[0]), .m0_b_ready(m_b_ready[0]), .m0_b_resp(m_b_resp[0]),
        .m1_ar_valid(m_ar_valid[1]), .m1_ar_ready(m_ar_ready[1]), .m1_ar_addr(m_ar_addr[1]),
        .m1_r_valid(m_r_valid[1]), .m1_r_ready(m_r_ready[1]), .m1_r_data(m_r_data[1]), .m1_r_resp(m_r_resp[1]),
        .m1_aw_valid(m_aw_valid[1]), .m1_aw_ready(m_aw_ready[1]), .m1_aw_addr(m_aw_addr[1]),
        .m1_w_valid(m_w_valid[1]), .m1_w_ready(m_w_ready[1]), .m1_w_data(m_w_data[1]), .m1_w_strb(m_w_strb[1]),
        .m1_b_valid(m_b_valid[1]), .m1_b_ready(m_b_ready[1]), .m1_b_resp(m_b_resp[1]),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr),
        .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data), .s_r_resp(s_r_resp),
        .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_addr(s_aw_addr),
        .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data), .s_w_strb(s_w_strb),
        .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_resp(s_b_resp),
        .gnt_o(gnt), .busy_o(busy)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] ref_mem[16];
    logic [31:0] smem[16];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++) if (s[b]) o[b*8 +: 8] = d[b*8 +: 8];
        return o;
    endfunction

    // Slave: random readies, one-cycle read latency, responses encode the address.
    logic       sl_ar_hs, sl_r_hs, sl_aw_hs, sl_w_hs, sl_b_hs, sl_rs, sl_rd_pend, sl_aw_got, sl_w_got;
    logic [3:0] sl_ra, sl_wa, sl_ws;
    logic [31:0] sl_wd;
    initial begin
        for (int i = 0; i < 16; i++) smem[i] = 32'hA5A5_0000 | i;
        {s_ar_ready, s_r_valid, s_aw_ready, s_w_ready, s_b_valid} = '0;
        s_r_data = '0; s_r_resp = '0; s_b_resp = '0;
        {sl_rd_pend, sl_aw_got, sl_w_got} = '0;
        forever begin
            @(negedge clk);
            sl_rs    = rst;
            sl_ar_hs = s_ar_valid && s_ar_ready;
            sl_r_hs  = s_r_valid && s_r_ready;
            sl_aw_hs = s_aw_valid && s_aw_ready;
            sl_w_hs  = s_w_valid && s_w_ready;
            sl_b_hs  = s_b_valid && s_b_ready;
            if (sl_ar_hs) sl_ra = s_ar_addr;
            @(posedge clk); #1;
            if (sl_rs) begin
                {s_r_valid, s_b_valid, sl_rd_pend, sl_aw_got, sl_w_got} = '0;
            end else begin
                if (sl_r_hs) begin s_r_valid = 1'b0; sl_rd_pend = 1'b0; end
                if (sl_b_hs) s_b_valid = 1'b0;
                if (sl_ar_hs) begin
                    chk("s_ar_once", sl_rd_pend, 0);
                    sl_rd_pend = 1'b1;
                    s_r_valid  = 1'b1;
                    s_r_data   = smem[sl_ra];
                    s_r_resp   = {sl_ra[0], 1'b0};
                end
                if (sl_aw_hs) begin
                    chk("s_aw_once", sl_aw_got | s_b_valid, 0);
                    sl_aw_got = 1'b1;
                    sl_wa = s_aw_addr;
                end
                if (sl_w_hs) begin
                    chk("s_w_once", sl_w_got | s_b_valid, 0);
                    sl_w_got = 1'b1;
                    sl_wd = s_w_data;
                    sl_ws = s_w_strb;
                end
                if (sl_aw_got && sl_w_got) begin
                    smem[sl_wa] = merge(smem[sl_wa], sl_wd, sl_ws);
                    s_b_valid = 1'b1;
                    s_b_resp  = {sl_wa[1], 1'b0};
                    sl_aw_got = 1'b0;
                    sl_w_got  = 1'b0;
                end
            end
            s_ar_ready = 1'($urandom_range(0, 1));
            s_aw_ready = 1'($urandom_range(0, 1));
            s_w_ready  = 1'($urandom_range(0, 1));
        end
    end

    // Transaction-level model: whoever was not served last wins a tie; a master
    // with both a read and a write pending alternates which goes first.
    int  mo_last, mo_cur, mo_o;
    bit  mo_pend, mo_erd, mo_rq0, mo_rq1, mo_rd, mo_wr;
    bit  mo_pref[2];
    initial begin
        mo_last = 1; mo_cur = 0; mo_pend = 0; mo_erd = 0;
        mo_pref[0] = 0; mo_pref[1] = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mo_last = 1; mo_pend = 0; mo_pref[0] = 0; mo_pref[1] = 0;
            end else begin
                if (mo_pend) begin
                    chk("grant_busy", busy, 1);
                    chk("grant_kind_rd", s_ar_valid, mo_erd);
                    chk("grant_kind_wr", s_aw_valid, !mo_erd);
                    mo_pend = 0;
                end
                if (!busy) begin
                    chk("idle_gnt", gnt, 0);
                    chk("idle_s", {s_ar_valid, s_aw_valid, s_w_valid, s_r_ready, s_b_ready}, 0);
                    chk("idle_m", {m_ar_ready[0], m_aw_ready[0], m_w_ready[0], m_r_valid[0], m_b_valid[0],
                                   m_ar_ready[1], m_aw_ready[1], m_w_ready[1], m_r_valid[1], m_b_valid[1]}, 0);
                    mo_rq0 = m_ar_valid[0] || (m_aw_valid[0] && m_w_valid[0]);
                    mo_rq1 = m_ar_valid[1] || (m_aw_valid[1] && m_w_valid[1]);
                    if (mo_rq0 || mo_rq1) begin
                        mo_cur = (mo_rq0 && mo_rq1) ? 1 - mo_last : (mo_rq0 ? 0 : 1);
                        mo_rd  = m_ar_valid[mo_cur];
                        mo_wr  = m_aw_valid[mo_cur] && m_w_valid[mo_cur];
                        mo_erd = mo_rd && !(mo_wr && mo_pref[mo_cur]);
                        if (mo_rd && mo_wr) mo_pref[mo_cur] = !mo_pref[mo_cur];
                        mo_pend = 1;
                    end
                end else begin
                    mo_o = 1 - mo_cur;
                    chk("gnt_hold", gnt, mo_cur == 1 ? 64'd2 : 64'd1);
                    chk("other_quiet", {m_ar_ready[mo_o], m_aw_ready[mo_o], m_w_ready[mo_o],
                                        m_r_valid[mo_o], m_b_valid[mo_o]}, 0);
                    if ((s_r_valid && s_r_ready) || (s_b_valid && s_b_ready)) mo_last = mo_cur;
                end
            end
        end
    end

    // One master: op 0 read, 1 write, 2 read+write together; -1 picks at random.
    task automatic master_run(input int n, input int cnt, input int fop);
        int op, stg, k;
        logic [3:0] ra, wa, ws;
        logic [31:0] wd, rdat;
        logic [1:0] rresp, bresp;
        bit need_r, need_b, w_sent, ar_hs, aw_hs, w_hs, r_hs, b_hs;
        for (int i = 0; i < cnt; i++) begin
            repeat (i == 0 ? 1 : $urandom_range(1, 3)) @(posedge clk);
            #1;
            op = fop >= 0 ? fop : int'($urandom_range(0, 2));
            ra = 4'($urandom); wa = 4'($urandom); wd = $urandom;
            ws = 4'($urandom_range(1, 15)); stg = $urandom_range(0, 2);
            need_r = op != 1; need_b = op != 0; w_sent = 0;
            if (need_r) begin m_ar_valid[n] = 1'b1; m_ar_addr[n] = ra; end
            if (need_b) begin
                m_aw_valid[n] = 1'b1; m_aw_addr[n] = wa; m_w_data[n] = wd; m_w_strb[n] = ws;
                if (stg == 0) begin m_w_valid[n] = 1'b1; w_sent = 1; end
            end
            k = 0;
            while ((need_r || need_b) && k < 400) begin
                m_r_ready[n] = $urandom_range(0, 2) != 0;
                m_b_ready[n] = $urandom_range(0, 2) != 0;
                @(negedge clk);
                ar_hs = m_ar_valid[n] && m_ar_ready[n];
                aw_hs = m_aw_valid[n] && m_aw_ready[n];
                w_hs  = m_w_valid[n] && m_w_ready[n];
                r_hs  = m_r_valid[n] && m_r_ready[n];
                b_hs  = m_b_valid[n] && m_b_ready[n];
                rdat = m_r_data[n]; rresp = m_r_resp[n]; bresp = m_b_resp[n];
                @(posedge clk); #1;
                k++;
                if (ar_hs) m_ar_valid[n] = 1'b0;
                if (aw_hs) m_aw_valid[n] = 1'b0;
                if (w_hs) m_w_valid[n] = 1'b0;
                if (need_b && !w_sent && k >= stg) begin m_w_valid[n] = 1'b1; w_sent = 1; end
                if (r_hs) begin
                    chk($sformatf("m%0d_rdata", n), rdat, ref_mem[ra]);
                    chk($sformatf("m%0d_rresp", n), rresp, {ra[0], 1'b0});
                    need_r = 0;
                end
                if (b_hs) begin
                    chk($sformatf("m%0d_bresp", n), bresp, {wa[1], 1'b0});
                    ref_mem[wa] = merge(ref_mem[wa], wd, ws);
                    need_b = 0;
                end
            end
            if (need_r || need_b) chk($sformatf("m%0d_timeout", n), 1, 0);
            m_r_ready[n] = 1'b0; m_b_ready[n] = 1'b0;
        end
    endtask

    bit got_b, d_aw_hs, d_w_hs;
    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'hA5A5_0000 | i;
        for (int n = 0; n < 2; n++) begin
            m_ar_valid[n] = 0; m_ar_addr[n] = 0; m_r_ready[n] = 0; m_aw_valid[n] = 0; m_aw_addr[n] = 0;
            m_w_valid[n] = 0; m_w_data[n] = 0; m_w_strb[n] = 0; m_b_ready[n] = 0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_s_valid", {s_ar_valid, s_aw_valid, s_w_valid, s_r_ready, s_b_ready}, 0);
        rst = 1'b0;
        fork
            master_run(0, 60, -1);
            master_run(1, 60, -1);
        join
        // Abort a write in its response phase with reset.
        m_aw_valid[1] = 1'b1; m_aw_addr[1] = 4'h7; m_w_valid[1] = 1'b1;
        m_w_data[1] = 32'h1234_5678; m_w_strb[1] = 4'hF; m_b_ready[1] = 1'b0;
        got_b = 0;
        for (int k = 0; k < 60 && !got_b; k++) begin
            @(negedge clk);
            got_b   = m_b_valid[1];
            d_aw_hs = m_aw_valid[1] && m_aw_ready[1];
            d_w_hs  = m_w_valid[1] && m_w_ready[1];
            @(posedge clk); #1;
            if (d_aw_hs) m_aw_valid[1] = 1'b0;
            if (d_w_hs) m_w_valid[1] = 1'b0;
        end
        chk("rst_setup_bvalid", got_b, 1);
        ref_mem[7] = 32'h1234_5678;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_gnt", gnt, 0);
        chk("abort_m1_bvalid", m_b_valid[1], 0);
        chk("abort_s_valid", {s_ar_valid, s_aw_valid, s_w_valid, s_b_ready}, 0);
        fork
            master_run(0, 3, 0);
            master_run(1, 3, 0);
        join
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
